uart_rx_cfg_bd: RTL and testbench

UART_RX_CFG_BD -- requirements
Module: uart_rx_cfg_bd

---
 rtl/uart_rx_cfg_bd.sv | 92 +++++++++
 tb/tb_uart_rx_cfg_bd.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg_bd.sv
// uart_rx_cfg_bd: 8N1 UART receiver; the bit period is taken from baud_cnt and held for the whole frame.
module uart_rx_cfg_bd #(
    parameter int BAUD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RX,
    input  logic [BAUD_W-1:0] baud_cnt,
    input  logic              clr_rdy,
    output logic [7:0]        rx_data,
    output logic              rdy,
    output logic              frm_err,
    output logic              ovr
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
    state_e            state_q, state_d;
    logic              s1_q, rx_s_q, rx_p_q;
    logic [BAUD_W-1:0] bd_q, bd_d, tmr_q, tmr_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        sh_q, sh_d, rx_data_d;
    logic              rdy_d, frm_err_d, ovr_d, tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s1_q    <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_p_q  <= 1'b1;
            bd_q    <= '0;
            tmr_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            rx_data <= '0;
            rdy     <= 1'b0;
            frm_err <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= RX;
            rx_s_q  <= s1_q;
            rx_p_q  <= rx_s_q;
            bd_q    <= bd_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            rx_data <= rx_data_d;
            rdy     <= rdy_d;
            frm_err <= frm_err_d;
            ovr     <= ovr_d;
        end
    end

    // A sample is taken on the cycle the timer sits at zero; it then reloads a full bit period.
    always_comb begin
        tick      = tmr_q == '0;
        state_d   = state_q;
        bd_d      = bd_q;
        tmr_d     = state_q == IDLE ? tmr_q : (tick ? bd_q - BAUD_W'(1) : tmr_q - BAUD_W'(1));
        idx_d     = idx_q;
        sh_d      = sh_q;
        rx_data_d = rx_data;
        rdy_d     = rdy & ~clr_rdy;
        ovr_d     = ovr & ~clr_rdy;
        frm_err_d = frm_err;
        case (state_q)
            IDLE: if (rx_p_q && !rx_s_q && baud_cnt >= BAUD_W'(16)) begin
                bd_d    = baud_cnt;
                tmr_d   = baud_cnt >> 1;
                state_d = START;
            end
            START: if (tick) begin
                state_d = rx_s_q ? IDLE : DATA;
                idx_d   = '0;
            end
            DATA: if (tick) begin
                sh_d    = {rx_s_q, sh_q[7:1]};
                idx_d   = idx_q + 3'd1;
                state_d = idx_q == 3'd7 ? STOP : DATA;
            end
            STOP: if (tick) begin
                state_d   = IDLE;
                frm_err_d = ~rx_s_q;
                if (rx_s_q) begin
                    rx_data_d = sh_q;
                    rdy_d     = 1'b1;
                    ovr_d     = rdy;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx_cfg_bd.sv
// tb_uart_rx_cfg_bd: directed frames checked against a sample-schedule model plus literal expectations.
module tb_uart_rx_cfg_bd;
    logic        clk = 1'b0;
    logic        rst, RX, clr_rdy;
    logic [15:0] baud_cnt;
    logic [7:0]  rx_data;
    logic        rdy, frm_err, ovr;
    int          n_chk = 0, n_fail = 0;

    uart_rx_cfg_bd #(.BAUD_W(16)) dut (
        .clk(clk), .rst(rst), .RX(RX), .baud_cnt(baud_cnt), .clr_rdy(clr_rdy),
        .rx_data(rx_data), .rdy(rdy), .frm_err(frm_err), .ovr(ovr)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: samples fall at fs + bd/2 + 1 + n*bd, fs being the clock edge that sees the synced line fall.
    logic       m_s1, m_s2, m_p, busy, nr, no;
    logic       armed = 1'b0;
    logic [7:0] m_sh, m_data;
    logic       m_rdy, m_fe, m_ovr;
    int         k = 0, fs, bd, off, n;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            armed = 1'b1; busy = 1'b0;
            m_s1 = 1'b1; m_s2 = 1'b1; m_p = 1'b1;
            m_data = 8'h00; m_rdy = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
        end else begin
            nr = m_rdy & ~clr_rdy;
            no = m_ovr & ~clr_rdy;
            if (!busy) begin
                if (m_p && !m_s2 && baud_cnt >= 16) begin
                    busy = 1'b1; fs = k; bd = int'(baud_cnt);
                end
            end else begin
                off = k - fs - bd / 2 - 1;
                if (off >= 0 && off % bd == 0) begin
                    n = off / bd;
                    if (n == 0) begin
                        if (m_s2) busy = 1'b0;
                    end else if (n <= 8) begin
                        m_sh[n-1] = m_s2;
                    end else begin
                        busy = 1'b0;
                        if (m_s2) begin
                            m_data = m_sh; nr = 1'b1; m_fe = 1'b0; no = m_rdy;
                        end else m_fe = 1'b1;
                    end
                end
            end
            m_rdy = nr; m_ovr = no;
            m_p = m_s2; m_s2 = m_s1; m_s1 = RX;
        end
        k++;
    end

    initial forever begin
        @(negedge clk);
        if (armed) begin
            cmp("model_rx_data", 32'(rx_data), 32'(m_data));
            cmp("model_rdy", 32'(rdy), 32'(m_rdy));
            cmp("model_frm_err", 32'(frm_err), 32'(m_fe));
            cmp("model_ovr", 32'(ovr), 32'(m_ovr));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stp, input int bdv);
        RX = 1'b0; tick(bdv);
        for (int i = 0; i < 8; i++) begin RX = b[i]; tick(bdv); end
        RX = stp; tick(bdv);
    endtask

    task automatic idle(input int c);
        RX = 1'b1; tick(c);
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1; tick(1); clr_rdy = 1'b0;
    endtask

    int         lat;
    logic [7:0] got [3];

    initial begin
        rst = 1'b1; RX = 1'b1; baud_cnt = 16'h0010; clr_rdy = 1'b0;
        tick(3);
        cmp("lit_reset_rdy", 32'(rdy), 0);
        cmp("lit_reset_rx_data", 32'(rx_data), 0);
        cmp("lit_reset_frm_err", 32'(frm_err), 0);
        cmp("lit_reset_ovr", 32'(ovr), 0);
        rst = 1'b0;
        idle(20);

        lat = -1;
        fork
            send(8'hA5, 1'b1, 16);
            for (int i = 0; i < 170; i++) begin
                @(posedge clk); #1;
                if (rdy && lat < 0) lat = i;
            end
        join
        cmp("lit_a5_latency", 32'(lat), 155);
        cmp("lit_a5_data", 32'(rx_data), 32'hA5);
        cmp("lit_a5_rdy", 32'(rdy), 1);
        cmp("lit_a5_frm_err", 32'(frm_err), 0);
        pulse_clr();
        cmp("lit_clr_rdy", 32'(rdy), 0);

        RX = 1'b0; tick(4); idle(40);
        cmp("lit_glitch_rdy", 32'(rdy), 0);
        cmp("lit_glitch_frm_err", 32'(frm_err), 0);
        send(8'h42, 1'b1, 16); idle(10);
        cmp("lit_after_glitch_data", 32'(rx_data), 32'h42);
        pulse_clr();

        baud_cnt = 16'h000F;
        send(8'h99, 1'b1, 15); idle(20);
        cmp("lit_slow_baud_rdy", 32'(rdy), 0);
        cmp("lit_slow_baud_data", 32'(rx_data), 32'h42);
        baud_cnt = 16'h0010;

        send(8'h3C, 1'b0, 16); idle(20);
        cmp("lit_ferr_flag", 32'(frm_err), 1);
        cmp("lit_ferr_rdy", 32'(rdy), 0);
        cmp("lit_ferr_data", 32'(rx_data), 32'h42);
        send(8'h81, 1'b1, 16); idle(4);
        cmp("lit_81_frm_err", 32'(frm_err), 0);
        cmp("lit_81_data", 32'(rx_data), 32'h81);
        pulse_clr();

        RX = 1'b0; tick(16 * 12);
        cmp("lit_break_frm_err", 32'(frm_err), 1);
        cmp("lit_break_rdy", 32'(rdy), 0);
        idle(30);

        send(8'h11, 1'b1, 16); send(8'h22, 1'b1, 16); idle(4);
        cmp("lit_ovr_data", 32'(rx_data), 32'h22);
        cmp("lit_ovr_rdy", 32'(rdy), 1);
        cmp("lit_ovr_flag", 32'(ovr), 1);
        pulse_clr();
        cmp("lit_ovr_clr_rdy", 32'(rdy), 0);
        cmp("lit_ovr_clr_ovr", 32'(ovr), 0);

        fork
            send(8'h7E, 1'b1, 16);
            begin tick(40); baud_cnt = 16'h0030; end
        join
        baud_cnt = 16'h0010; idle(4);
        cmp("lit_baud_change_data", 32'(rx_data), 32'h7E);
        cmp("lit_baud_change_ovr", 32'(ovr), 0);
        fork
            send(8'h55, 1'b1, 16);
            begin tick(155); clr_rdy = 1'b1; tick(1); clr_rdy = 1'b0; end
        join
        idle(4);
        cmp("lit_collide_rdy", 32'(rdy), 1);
        cmp("lit_collide_ovr", 32'(ovr), 1);
        cmp("lit_collide_data", 32'(rx_data), 32'h55);
        pulse_clr();
        cmp("lit_collide_clr_ovr", 32'(ovr), 0);

        baud_cnt = 16'h0101;
        got = '{8'h00, 8'h00, 8'h00};
        fork
            begin send(8'hAA, 1'b1, 257); send(8'hCC, 1'b1, 257); send(8'h88, 1'b1, 257); end
            for (int j = 0; j < 3; j++) begin
                for (int c = 0; c < 4000 && !rdy; c++) tick(1);
                got[j] = rx_data;
                pulse_clr();
            end
        join
        cmp("lit_b2b_0", 32'(got[0]), 32'hAA);
        cmp("lit_b2b_1", 32'(got[1]), 32'hCC);
        cmp("lit_b2b_2", 32'(got[2]), 32'h88);
        cmp("lit_b2b_ovr", 32'(ovr), 0);
        baud_cnt = 16'h0010; idle(10);

        RX = 1'b0; tick(16 + 64);
        RX = 1'b1; tick(8);
        rst = 1'b1; tick(1); rst = 1'b0;
        idle(30);
        cmp("lit_abort_rdy", 32'(rdy), 0);
        cmp("lit_abort_data", 32'(rx_data), 0);
        send(8'h5A, 1'b1, 16); idle(4);
        cmp("lit_post_rst_data", 32'(rx_data), 32'h5A);
        cmp("lit_post_rst_rdy", 32'(rdy), 1);
        cmp("lit_post_rst_frm_err", 32'(frm_err), 0);

        idle(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
